// File: rtl/imm_gen_stream_if.sv
// rtl/imm_gen_stream_if.sv - instruction-in / immediate-out stream bundle for imm_gen_stream
interface imm_gen_stream_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 4
);
    localparam int LW = $clog2(DEPTH + 1);

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [2:0]       in_imm_src;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;
    logic [LW-1:0]    level;

    modport master (
        output flush, in_valid, in_instr, in_imm_src, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_illegal, out_tag, level
    );

    modport slave (
        input  flush, in_valid, in_instr, in_imm_src, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_illegal, out_tag, level
    );
endinterface

// File: rtl/imm_gen_stream.sv
// rtl/imm_gen_stream.sv - RISC-V immediate decoder feeding a DEPTH-entry output FIFO
module imm_gen_stream #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    imm_gen_stream_if.slave  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        SRC_I = 3'b000,
        SRC_S = 3'b001,
        SRC_B = 3'b010,
        SRC_U = 3'b011,
        SRC_J = 3'b100,
        SRC_Z = 3'b101
    } imm_src_e;

    logic [31:0]      inst;
    logic [31:0]      imm32;
    logic             dec_illegal;
    logic [XLEN-1:0]  dec_imm;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q,  level_d;

    logic [XLEN-1:0]  mem_imm_q [DEPTH];
    logic             mem_ill_q [DEPTH];
    logic [TAG_W-1:0] mem_tag_q [DEPTH];

    logic             push;
    logic             pop;
    logic             head_valid;

    assign inst = bus.in_instr;

    // Every format is built as a 32-bit signed value first; Z keeps bit 31 clear so it stays zero-extended.
    always_comb begin
        imm32       = '0;
        dec_illegal = 1'b0;
        case (bus.in_imm_src)
            SRC_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
            SRC_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            SRC_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            SRC_U:   imm32 = {inst[31:12], 12'b0};
            SRC_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            SRC_Z:   imm32 = {27'b0, inst[19:15]};
            default: dec_illegal = 1'b1;
        endcase
    end

    assign dec_imm = XLEN'($signed(imm32));

    // in_ready depends only on registered occupancy, so a pop never frees a slot in the same cycle.
    assign bus.in_ready = (level_q != LW'(DEPTH));
    assign head_valid   = (level_q != '0);
    assign push         = bus.in_valid && bus.in_ready && !bus.flush;
    assign pop          = head_valid && bus.out_ready && !bus.flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Payload storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_imm_q[wr_ptr_q] <= dec_illegal ? '0 : dec_imm;
            mem_ill_q[wr_ptr_q] <= dec_illegal;
            mem_tag_q[wr_ptr_q] <= bus.in_tag;
        end
    end

    assign bus.out_valid   = head_valid;
    assign bus.out_imm     = head_valid ? mem_imm_q[rd_ptr_q] : '0;
    assign bus.out_illegal = head_valid ? mem_ill_q[rd_ptr_q] : 1'b0;
    assign bus.out_tag     = head_valid ? mem_tag_q[rd_ptr_q] : '0;
    assign bus.level       = level_q;
endmodule

// File: tb/tb_imm_gen_stream.sv
// tb/tb_imm_gen_stream.sv - directed-vector bench for imm_gen_stream at XLEN 32 and 64
module tb_imm_gen_stream;
    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    imm_gen_stream_if #(.XLEN(32), .DEPTH(2), .TAG_W(4)) if32 ();
    imm_gen_stream_if #(.XLEN(64), .DEPTH(2), .TAG_W(4)) if64 ();

    imm_gen_stream #(.XLEN(32), .DEPTH(2), .TAG_W(4)) u_dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if32.slave)
    );

    imm_gen_stream #(.XLEN(64), .DEPTH(2), .TAG_W(4)) u_dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if64.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive32(input logic v, input logic [2:0] src, input logic [31:0] ins, input logic [3:0] tg);
        if32.in_valid   = v;
        if32.in_imm_src = src;
        if32.in_instr   = ins;
        if32.in_tag     = tg;
    endtask

    logic [2:0]  f_src [7];
    logic [31:0] f_ins [7];
    logic [31:0] f_exp [7];

    initial begin
        n_total = 0;
        n_bad   = 0;
        f_src[0] = 3'b000; f_ins[0] = 32'h1A300000; f_exp[0] = 32'h000001a3;
        f_src[1] = 3'b000; f_ins[1] = 32'hEC400000; f_exp[1] = 32'hfffffec4;
        f_src[2] = 3'b001; f_ins[2] = 32'h68000A80; f_exp[2] = 32'h00000695;
        f_src[3] = 3'b010; f_ins[3] = 32'hFE000FE3; f_exp[3] = 32'hfffffffe;
        f_src[4] = 3'b011; f_ins[4] = 32'h12345037; f_exp[4] = 32'h12345000;
        f_src[5] = 3'b100; f_ins[5] = 32'h0080006F; f_exp[5] = 32'h00000008;
        f_src[6] = 3'b101; f_ins[6] = 32'h000F8073; f_exp[6] = 32'h0000001f;

        rst_n = 1'b0;
        if32.flush = 1'b0; if32.out_ready = 1'b1;
        drive32(1'b0, 3'b000, 32'h0, 4'h0);
        if64.flush = 1'b0; if64.out_ready = 1'b1; if64.in_valid = 1'b0;
        if64.in_imm_src = 3'b000; if64.in_instr = 32'h0; if64.in_tag = 4'h0;

        @(negedge clk);
        chk("rst_level", 64'(if32.level), 64'd0);
        chk("rst_in_ready", 64'(if32.in_ready), 64'd1);
        chk("rst_out_valid", 64'(if32.out_valid), 64'd0);
        chk("rst_out_imm", 64'(if32.out_imm), 64'd0);
        rst_n = 1'b1;

        // Format stream, one accept per cycle, checked one cycle later
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            if (k < 7) drive32(1'b1, f_src[k], f_ins[k], 4'(k));
            else       drive32(1'b0, 3'b000, 32'h0, 4'h0);
            @(negedge clk);
            if (k < 7) begin
                chk($sformatf("fmt%0d_valid", k), 64'(if32.out_valid), 64'd1);
                chk($sformatf("fmt%0d_imm", k), 64'(if32.out_imm), 64'(f_exp[k]));
                chk($sformatf("fmt%0d_tag", k), 64'(if32.out_tag), 64'(k));
                chk($sformatf("fmt%0d_ill", k), 64'(if32.out_illegal), 64'd0);
            end else begin
                chk("drain_valid", 64'(if32.out_valid), 64'd0);
                chk("drain_imm", 64'(if32.out_imm), 64'd0);
            end
        end

        // XLEN=64 sign extension
        if64.in_valid = 1'b1; if64.in_imm_src = 3'b011; if64.in_instr = 32'h80000037; if64.in_tag = 4'h1;
        @(negedge clk);
        chk("x64_u_imm", if64.out_imm, 64'hffffffff80000000);
        chk("x64_u_tag", 64'(if64.out_tag), 64'h1);
        if64.in_imm_src = 3'b000; if64.in_instr = 32'hEC400000; if64.in_tag = 4'h2;
        @(negedge clk);
        chk("x64_i_imm", if64.out_imm, 64'hfffffffffffffec4);
        if64.in_valid = 1'b0;
        @(negedge clk);
        chk("x64_drain", 64'(if64.out_valid), 64'd0);

        // Illegal format
        drive32(1'b1, 3'b110, 32'hFFFFFFFF, 4'h5);
        @(negedge clk);
        chk("ill_imm", 64'(if32.out_imm), 64'd0);
        chk("ill_flag", 64'(if32.out_illegal), 64'd1);
        chk("ill_tag", 64'(if32.out_tag), 64'h5);
        chk("ill_valid", 64'(if32.out_valid), 64'd1);
        drive32(1'b1, 3'b000, 32'h1A300000, 4'h6);
        @(negedge clk);
        chk("post_ill_flag", 64'(if32.out_illegal), 64'd0);
        chk("post_ill_imm", 64'(if32.out_imm), 64'h1a3);
        drive32(1'b0, 3'b111, 32'h0, 4'h0);
        @(negedge clk);

        // Backpressure: tags 1,2,3 with out_ready low; imm equals tag
        if32.out_ready = 1'b0;
        drive32(1'b1, 3'b000, 32'h00100000, 4'h1);
        @(negedge clk);
        chk("bp_level1", 64'(if32.level), 64'd1);
        chk("bp_rdy1", 64'(if32.in_ready), 64'd1);
        drive32(1'b1, 3'b000, 32'h00200000, 4'h2);
        @(negedge clk);
        chk("bp_level2", 64'(if32.level), 64'd2);
        chk("bp_rdy_full", 64'(if32.in_ready), 64'd0);
        chk("bp_head1", 64'(if32.out_tag), 64'h1);
        drive32(1'b1, 3'b000, 32'h00300000, 4'h3);
        @(negedge clk);
        chk("bp_hold_level", 64'(if32.level), 64'd2);
        chk("bp_hold_tag", 64'(if32.out_tag), 64'h1);
        chk("bp_hold_imm", 64'(if32.out_imm), 64'h1);
        chk("bp_hold_rdy", 64'(if32.in_ready), 64'd0);
        if32.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_pop1_tag", 64'(if32.out_tag), 64'h2);
        chk("bp_pop1_level", 64'(if32.level), 64'd1);
        chk("bp_pop1_rdy", 64'(if32.in_ready), 64'd1);
        @(negedge clk);
        chk("bp_pop2_tag", 64'(if32.out_tag), 64'h3);
        chk("bp_pop2_imm", 64'(if32.out_imm), 64'h3);
        chk("bp_pop2_level", 64'(if32.level), 64'd1);
        drive32(1'b0, 3'b000, 32'h0, 4'h0);
        @(negedge clk);
        chk("bp_empty", 64'(if32.out_valid), 64'd0);
        chk("bp_empty_level", 64'(if32.level), 64'd0);

        // Flush with a full FIFO, concurrent push and pop requested
        if32.out_ready = 1'b0;
        drive32(1'b1, 3'b000, 32'h00700000, 4'h7);
        @(negedge clk);
        drive32(1'b1, 3'b000, 32'h00800000, 4'h8);
        @(negedge clk);
        chk("fl_pre_level", 64'(if32.level), 64'd2);
        if32.flush = 1'b1; if32.out_ready = 1'b1;
        drive32(1'b1, 3'b000, 32'h00900000, 4'h9);
        @(negedge clk);
        if32.flush = 1'b0;
        drive32(1'b0, 3'b000, 32'h0, 4'h0);
        chk("fl_level", 64'(if32.level), 64'd0);
        chk("fl_valid", 64'(if32.out_valid), 64'd0);
        chk("fl_rdy", 64'(if32.in_ready), 64'd1);
        @(negedge clk);
        chk("fl_stay_empty", 64'(if32.level), 64'd0);

        // Asynchronous reset with one entry buffered
        if32.out_ready = 1'b0;
        drive32(1'b1, 3'b000, 32'h1A300000, 4'hA);
        @(negedge clk);
        drive32(1'b0, 3'b000, 32'h0, 4'h0);
        chk("ar_pre_level", 64'(if32.level), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_level", 64'(if32.level), 64'd0);
        chk("ar_valid", 64'(if32.out_valid), 64'd0);
        chk("ar_imm", 64'(if32.out_imm), 64'd0);
        chk("ar_tag", 64'(if32.out_tag), 64'd0);
        chk("ar_rdy", 64'(if32.in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        if32.out_ready = 1'b1;
        drive32(1'b1, 3'b000, 32'hEC400000, 4'h9);
        @(negedge clk);
        drive32(1'b0, 3'b000, 32'h0, 4'h0);
        chk("ar_post_valid", 64'(if32.out_valid), 64'd1);
        chk("ar_post_imm", 64'(if32.out_imm), 64'hfffffec4);
        chk("ar_post_tag", 64'(if32.out_tag), 64'h9);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/imm_gen_stream.md
# imm_gen_stream

Streaming, parametrised immediate generator for the RISC-V datapath. It accepts an instruction word with an immediate-format select and emits the sign- or zero-extended immediate after one registered stage. Results pass through an internal DEPTH-entry FIFO with valid/ready handshakes on both sides. It supersedes the 2-bit, 32-bit-only combinational immediate generator, adding U/J/CSR-zimm formats, XLEN=64 support, an illegal-format flag, and backpressure for the pipelined core.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64
- DEPTH, 2, output FIFO entries; power of two, ≥2
- TAG_W, 4, width of sideband tag carried alongside each instruction
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous; discards all buffered entries
- in_valid  input  1  instruction presented
- in_ready  output  1  block can accept this cycle
- in_instr  input  32  instruction word
- in_imm_src  input  3  format: 000 I, 001 S, 010 B, 011 U, 100 J, 101 Z (CSR zimm), 110/111 illegal
- in_tag  input  TAG_W  opaque tag, returned unchanged
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer accepts head
- out_imm  output  XLEN  generated immediate
- out_illegal  output  1  in_imm_src was 110/111
- out_tag  output  TAG_W  tag of head entry
- level  output  $clog2(DEPTH+1)  current occupancy

## Operation
- Accept on rising edge when in_valid && in_ready && !flush; decoded result written into FIFO tail.
- Immediate formats (inst = in_instr), sign-extended from the top immediate bit to XLEN:
  - I: inst[31:20]
  - S: {inst[31:25], inst[11:7]}
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}
  - U: {inst[31:12], 12'b0}; for XLEN=64 bit 31 is replicated into [63:32]
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}
  - Z: inst[19:15], zero-extended
  - 110/111: out_imm = 0, out_illegal = 1; entry still occupies the FIFO
- Pop on rising edge when out_valid && out_ready.
- FIFO order is strict; tag travels with its immediate.
- in_ready = (level != DEPTH), derived from registered state only, with no combinational path from out_ready.
- When full, a same-cycle pop does not enable a push; in_ready stays low that cycle.
- When level is 0 < level < DEPTH, simultaneous push and pop leave level unchanged.
- When out_valid = 0, out_imm, out_tag and out_illegal read 0.
- While out_valid && !out_ready, head outputs hold stable.
- flush: on the edge where flush = 1, level becomes 0 and pointers reset. Push and pop in that cycle are ignored. flush overrides all.
- Reset (asynchronous, any time, including mid-stream):
  - level = 0, out_valid = 0, out_imm/out_tag/out_illegal = 0, pointers = 0
  - in_ready = 1 while and after reset
  - Buffered entries are lost.

## Timing
- Latency: instruction accepted at edge N appears with out_valid = 1 in the cycle following edge N, i.e. one cycle.
- Throughput: one instruction per cycle when out_ready is held high.
- level updates on the same edge as push/pop.
- in_ready deasserts in the cycle after the accept that fills the FIFO.
- in_ready reasserts in the cycle after the first pop from full.
- No bypass path; an empty FIFO never presents same-cycle input.

## Test plan
- Formats, XLEN=32, out_ready=1, one instruction per cycle; each result appears one cycle after its accept:
  - I 32'h1A300000 -> 32'h000001a3
  - I 32'hEC400000 -> 32'hfffffec4
  - S 32'h68000A80 -> 32'h00000695
  - B 32'hFE000FE3 -> 32'hfffffffe
  - U 32'h12345037 -> 32'h12345000
  - J 32'h0080006F -> 32'h00000008
  - Z 32'h000F8073 -> 32'h0000001f
- XLEN=64:
  - U 32'h80000037 -> 64'hffffffff80000000
  - I 32'hEC400000 -> 64'hfffffffffffffec4
- Illegal: src 110, instr 32'hFFFFFFFF, tag 4'h5 -> out_imm 0, out_illegal 1, out_tag 4'h5; the next legal entry has out_illegal 0.
- Backpressure, DEPTH=2, out_ready=0, three back-to-back pushes, tags 1,2,3:
  - tags 1,2 accepted; level = 2; in_ready low; tag 3 held by source
  - raise out_ready: output order 1,2,3, with in_ready returning the cycle after the first pop
- Flush, level = 2, flush pulsed with in_valid = 1 and out_ready = 1:
  - next cycle: level = 0, out_valid = 0, nothing popped or pushed
  - in_ready = 1
- Reset mid-stream: assert rst_n low asynchronously between edges with level = 1.
  - Outputs go to 0 immediately and level = 0.
  - After release, the first accepted instruction emerges one cycle later with correct value.
